// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared state encodings and op codes for the calculator front end
package calc_pkg;

  typedef enum logic [2:0] {
    S_A    = 3'b000,
    S_B    = 3'b001,
    S_OP   = 3'b010,
    S_CALC = 3'b011,
    S_SHOW = 3'b100
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;

  localparam logic [2:0] OP_MAX_LEGAL = 3'b101;

  function automatic logic op_legal(input logic [2:0] op);
    return op <= OP_MAX_LEGAL;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - push-button synchronizer, debouncer and press pulse
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic pulse
);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic             level_q;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      pulse   <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_q <= level;
      pulse   <= level & ~level_q;
      // Any sample agreeing with the accepted level restarts the stability run.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/calc_input_seq.sv
// rtl/calc_input_seq.sv - collects A, B and op from switches per ENTER press, captures ALU result
module calc_input_seq
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sw,
  input  logic       btn_enter,
  input  logic       btn_clear,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_op,
  input  logic [3:0] alu_result,
  output logic [3:0] disp_value,
  output logic       disp_valid,
  output logic       op_err,
  output logic [2:0] state_code
);

  logic       enter_p;
  logic       clear_p;
  logic [3:0] sw_s1;
  logic [3:0] sw_s;

  state_t     state, state_n;
  logic [3:0] a_n, b_n, disp_r, disp_n;
  logic [2:0] op_n;
  logic       valid_n, err_n;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_enter (
    .clk(clk), .rst(rst), .raw(btn_enter), .pulse(enter_p)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_clear (
    .clk(clk), .rst(rst), .raw(btn_clear), .pulse(clear_p)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_s1      <= '0;
      sw_s       <= '0;
      state      <= S_A;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      disp_r     <= '0;
      disp_valid <= 1'b0;
      op_err     <= 1'b0;
    end else begin
      sw_s1      <= sw;
      sw_s       <= sw_s1;
      state      <= state_n;
      alu_a      <= a_n;
      alu_b      <= b_n;
      alu_op     <= op_n;
      disp_r     <= disp_n;
      disp_valid <= valid_n;
      op_err     <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    a_n     = alu_a;
    b_n     = alu_b;
    op_n    = alu_op;
    disp_n  = disp_r;
    valid_n = disp_valid;
    err_n   = op_err;
    // Clear outranks a simultaneous enter.
    if (clear_p) begin
      state_n = S_A;
      a_n     = '0;
      b_n     = '0;
      op_n    = '0;
      disp_n  = '0;
      valid_n = 1'b0;
      err_n   = 1'b0;
    end else begin
      case (state)
        S_A: if (enter_p) begin
          a_n     = sw_s;
          state_n = S_B;
        end
        S_B: if (enter_p) begin
          b_n     = sw_s;
          state_n = S_OP;
        end
        S_OP: if (enter_p) begin
          if (op_legal(sw_s[2:0])) begin
            op_n    = sw_s[2:0];
            err_n   = 1'b0;
            state_n = S_CALC;
          end else begin
            err_n = 1'b1;
          end
        end
        S_CALC: begin
          disp_n  = alu_result;
          valid_n = 1'b1;
          state_n = S_SHOW;
        end
        S_SHOW: if (enter_p) begin
          valid_n = 1'b0;
          state_n = S_A;
        end
        default: state_n = S_A;
      endcase
    end
  end

  // While entering values the display previews the switches.
  assign disp_value = (state == S_CALC || state == S_SHOW) ? disp_r : sw_s;
  assign state_code = state;

endmodule

// File: tb/tb_calc_input_seq.sv
// tb/tb_calc_input_seq.sv - randomized and directed bench with a behavioural reference model
module tb_calc_input_seq;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sw = 4'h0;
  logic       btn_enter = 1'b0;
  logic       btn_clear = 1'b0;
  logic [3:0] alu_a, alu_b, alu_result, disp_value;
  logic [2:0] alu_op, state_code;
  logic       disp_valid, op_err;

  int checks = 0;
  int failures = 0;
  bit run = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [3:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ~a;
      default: return 4'h0;
    endcase
  endfunction

  assign alu_result = alu_f(alu_a, alu_b, alu_op);

  calc_input_seq #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .sw(sw), .btn_enter(btn_enter), .btn_clear(btn_clear),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .disp_value(disp_value), .disp_valid(disp_valid), .op_err(op_err),
    .state_code(state_code)
  );

  // Reference model: buttons as "last D synced samples all disagree" windows, FSM from the rules.
  int         m_state;
  logic [3:0] m_a, m_b, m_disp, m_sw1, m_sws;
  logic [2:0] m_op;
  logic       m_valid, m_err;
  logic       m_s1[2], m_s2[2], m_lvl[2], m_rose[2], m_pulse[2];
  logic       m_win[2][D];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state = 0; m_a = 0; m_b = 0; m_op = 0; m_disp = 0; m_valid = 0; m_err = 0;
      m_sw1 = 0; m_sws = 0;
      for (int i = 0; i < 2; i++) begin
        m_s1[i] = 0; m_s2[i] = 0; m_lvl[i] = 0; m_rose[i] = 0; m_pulse[i] = 0;
        for (int k = 0; k < D; k++) m_win[i][k] = 0;
      end
    end else begin
      logic e, c, raw_i, all_diff;
      e = m_pulse[0];
      c = m_pulse[1];
      if (c) begin
        m_state = 0; m_a = 0; m_b = 0; m_op = 0; m_disp = 0; m_valid = 0; m_err = 0;
      end else begin
        case (m_state)
          0: if (e) begin m_a = m_sws; m_state = 1; end
          1: if (e) begin m_b = m_sws; m_state = 2; end
          2: if (e) begin
               if (m_sws[2:0] <= 3'd5) begin m_op = m_sws[2:0]; m_err = 0; m_state = 3; end
               else m_err = 1;
             end
          3: begin m_disp = alu_f(m_a, m_b, m_op); m_valid = 1; m_state = 4; end
          default: if (e) begin m_valid = 0; m_state = 0; end
        endcase
      end
      for (int i = 0; i < 2; i++) begin
        raw_i = (i == 0) ? btn_enter : btn_clear;
        for (int k = 0; k < D - 1; k++) m_win[i][k] = m_win[i][k+1];
        m_win[i][D-1] = m_s2[i];
        all_diff = 1;
        for (int k = 0; k < D; k++) if (m_win[i][k] == m_lvl[i]) all_diff = 0;
        m_pulse[i] = m_rose[i];
        if (all_diff) begin
          m_lvl[i]  = ~m_lvl[i];
          m_rose[i] = m_lvl[i];
        end else begin
          m_rose[i] = 0;
        end
        m_s2[i] = m_s1[i];
        m_s1[i] = raw_i;
      end
      m_sws = m_sw1;
      m_sw1 = sw;
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (run) begin
      chk("alu_a", 8'(alu_a), 8'(m_a));
      chk("alu_b", 8'(alu_b), 8'(m_b));
      chk("alu_op", 8'(alu_op), 8'(m_op));
      chk("disp_value", 8'(disp_value), 8'((m_state >= 3) ? m_disp : m_sws));
      chk("disp_valid", 8'(disp_valid), 8'(m_valid));
      chk("op_err", 8'(op_err), 8'(m_err));
      chk("state_code", 8'(state_code), 8'(m_state));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic press(input logic [3:0] v);
    sw = v;
    tick(3);
    btn_enter = 1'b1;
    tick(10);
    btn_enter = 1'b0;
    tick(10);
  endtask

  task automatic check_zero(input string name);
    chk({name, "_a"}, 8'(alu_a), 8'h0);
    chk({name, "_b"}, 8'(alu_b), 8'h0);
    chk({name, "_op"}, 8'(alu_op), 8'h0);
    chk({name, "_disp"}, 8'(disp_value), 8'h0);
    chk({name, "_valid"}, 8'(disp_valid), 8'h0);
    chk({name, "_err"}, 8'(op_err), 8'h0);
    chk({name, "_state"}, 8'(state_code), 8'h0);
  endtask

  initial begin
    rst = 1'b1;
    #1;
    check_zero("reset");
    tick(3);
    rst = 1'b0;
    run = 1'b1;
    tick(2);

    // 3 + 5 = 8
    press(4'h3); press(4'h5); press(4'h0);
    chk("t1_disp", 8'(disp_value), 8'h8);
    chk("t1_valid", 8'(disp_valid), 8'h1);
    chk("t1_state", 8'(state_code), 8'h4);

    // 2 - 5 wraps to D, then back to entry with live preview
    press(4'h0);
    press(4'h2); press(4'h5); press(4'h1);
    chk("t2_disp", 8'(disp_value), 8'hD);
    press(4'h7);
    chk("t2_valid", 8'(disp_valid), 8'h0);
    chk("t2_state", 8'(state_code), 8'h0);
    sw = 4'h9;
    tick(3);
    chk("t2_preview", 8'(disp_value), 8'h9);

    // bouncy press shorter than the debounce window
    sw = 4'hC;
    tick(3);
    btn_enter = 1; tick(2); btn_enter = 0; tick(1);
    btn_enter = 1; tick(2); btn_enter = 0; tick(10);
    chk("t3_bounce_state", 8'(state_code), 8'h0);
    btn_enter = 1; tick(8); btn_enter = 0; tick(10);
    chk("t3_state", 8'(state_code), 8'h1);
    chk("t3_a", 8'(alu_a), 8'hC);

    // illegal op then XOR: C ^ A = 6
    press(4'hA);
    press(4'h6);
    chk("t4_err", 8'(op_err), 8'h1);
    chk("t4_state", 8'(state_code), 8'h2);
    chk("t4_op_kept", 8'(alu_op), 8'h1);
    press(4'h4);
    chk("t4_err_clr", 8'(op_err), 8'h0);
    chk("t4_disp", 8'(disp_value), 8'h6);

    // clear and enter together in S_B
    press(4'h0);
    press(4'h3);
    chk("t5_pre_state", 8'(state_code), 8'h1);
    sw = 4'h5;
    tick(3);
    btn_enter = 1; btn_clear = 1; tick(10);
    btn_enter = 0; btn_clear = 0; tick(10);
    chk("t5_state", 8'(state_code), 8'h0);
    chk("t5_a", 8'(alu_a), 8'h0);

    // asynchronous reset while showing a result
    press(4'h1); press(4'h2); press(4'h0);
    chk("t5_show", 8'(state_code), 8'h4);
    sw = 4'h0;
    tick(3);
    rst = 1'b1;
    #1;
    check_zero("t5_rst");
    tick(2);
    rst = 1'b0;
    tick(2);

    // NOT ignores B: ~9 = 6
    press(4'h9); press(4'hF); press(4'h5);
    chk("t6_disp", 8'(disp_value), 8'h6);

    // randomized buttons, hold lengths and switches against the model
    for (int it = 0; it < 200; it++) begin
      sw = 4'($urandom);
      btn_clear = ($urandom_range(0, 9) == 0);
      btn_enter = 1'b1;
      tick($urandom_range(1, 10));
      btn_enter = 1'b0;
      if ($urandom_range(0, 3) == 0) sw = 4'($urandom);
      tick($urandom_range(1, 4));
      btn_clear = 1'b0;
      tick($urandom_range(1, 8));
    end
    tick(12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
